// File: rtl/dec_mpp_recon.sv
// MPP reconstruction: maps substream residuals to component order, rebuilds
// each component against its midpoint one per cycle, and presents the block
// on a valid/ready output.
// Optional feature macro: MPP_MEAN_ROUND_EN (round the stored component mean).
// Ports: clk, rstn (sync, active-low);
//   in_vld/in_rdy/in_qres/in_step: residual block input;
//   slice_start: next block opens a slice;
//   out_vld/out_rdy/out_pix: reconstructed block output;
//   blk_cnt: blocks output since slice start.
module dec_mpp_recon #(
  parameter int NCOMP    = 3,
  parameter int NSAMP    = 16,
  parameter int QW       = 8,
  parameter int BITDEPTH = 8,
  parameter int HEAD     = NSAMP / 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              in_vld,
  output logic                              in_rdy,
  input  logic [(NCOMP+1)*NSAMP*QW-1:0]     in_qres,
  input  logic [2:0]                        in_step,
  input  logic                              slice_start,
  output logic                              out_vld,
  input  logic                              out_rdy,
  output logic [NCOMP*NSAMP*BITDEPTH-1:0]   out_pix,
  output logic [15:0]                       blk_cnt
);

  localparam int LS = $clog2(NSAMP);
  localparam int IW = QW + BITDEPTH + 8;
  localparam int SW = BITDEPTH + LS;
  localparam int CW = (NCOMP > 1) ? $clog2(NCOMP) : 1;
  localparam int BW = NSAMP * BITDEPTH;

  localparam logic [BITDEPTH-1:0] HALF =
    {1'b1, {(BITDEPTH-1){1'b0}}};
  localparam logic signed [IW-1:0] VMAX =
    IW'((1 << BITDEPTH) - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECON,
    OUT
  } state_t;

  state_t state, state_nx;

  logic [QW-1:0]       qr   [NCOMP][NSAMP];
  logic [QW-1:0]       mq   [NCOMP][NSAMP];
  logic [BITDEPTH-1:0] mean [NCOMP];
  logic [2:0]          step_q;
  logic                first;
  logic                pend;
  logic [CW-1:0]       comp;
  logic                last_comp;

  assign last_comp = (comp == CW'(NCOMP - 1));

  // Substream 0 carries the first HEAD samples of every component;
  // substream c+1 carries the tail of component c.
  always_comb begin
    for (int c = 0; c < NCOMP; c++) begin
      for (int s = 0; s < NSAMP; s++) begin
        if (s < HEAD)
          mq[c][s] = in_qres[(c*HEAD+s)*QW +: QW];
        else
          mq[c][s] = in_qres[((c+1)*NSAMP+s-HEAD)*QW +: QW];
      end
    end
  end

  logic [BITDEPTH-1:0]        mp_c;
  logic signed [IW-1:0]       t;
  logic signed [IW-1:0]       v;
  logic [BITDEPTH-1:0]        r;
  logic [SW-1:0]              sum;
  logic [SW-1:0]              msum;
  logic [BITDEPTH-1:0]        mnew;
  logic [BW-1:0]              rvec;

  always_comb begin
    mp_c = first ? HALF : mean[comp];
    sum  = '0;
    rvec = '0;
    t    = '0;
    v    = '0;
    r    = '0;
    for (int s = 0; s < NSAMP; s++) begin
      t = {{(IW-QW){qr[comp][s][QW-1]}}, qr[comp][s]};
      t = t <<< step_q;
      v = $signed({{(IW-BITDEPTH){1'b0}}, mp_c}) + t;
      if (v < 0)
        r = '0;
      else if (v > VMAX)
        r = '1;
      else
        r = v[BITDEPTH-1:0];
      rvec[s*BITDEPTH +: BITDEPTH] = r;
      sum = sum + SW'(r);
    end
`ifdef MPP_MEAN_ROUND_EN
    msum = sum + SW'(NSAMP / 2);
`else
    msum = sum;
`endif
    mnew = msum[SW-1:LS];
  end

  always_comb begin
    state_nx = state;
    in_rdy   = 1'b0;
    out_vld  = 1'b0;
    unique case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) state_nx = RECON;
      end
      RECON: begin
        if (last_comp) state_nx = OUT;
      end
      OUT: begin
        out_vld = 1'b1;
        if (out_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_pix <= '0;
      blk_cnt <= '0;
      step_q  <= '0;
      first   <= 1'b0;
      pend    <= 1'b0;
      comp    <= '0;
      for (int c = 0; c < NCOMP; c++) begin
        mean[c] <= HALF;
        for (int s = 0; s < NSAMP; s++)
          qr[c][s] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (slice_start) begin
            blk_cnt <= '0;
            for (int c = 0; c < NCOMP; c++)
              mean[c] <= HALF;
          end
          if (in_vld) begin
            qr     <= mq;
            step_q <= in_step;
            first  <= slice_start | (blk_cnt == 16'd0);
            comp   <= '0;
          end
        end
        RECON: begin
          out_pix[comp*BW +: BW] <= rvec;
          mean[comp]             <= mnew;
          comp <= last_comp ? '0 : comp + CW'(1);
          if (slice_start) pend <= 1'b1;
        end
        OUT: begin
          if (out_rdy) begin
            // A slice start seen mid-block takes effect on return to IDLE.
            if (pend | slice_start) begin
              blk_cnt <= '0;
              pend    <= 1'b0;
              for (int c = 0; c < NCOMP; c++)
                mean[c] <= HALF;
            end else if (blk_cnt != 16'hFFFF) begin
              blk_cnt <= blk_cnt + 16'd1;
            end
          end else if (slice_start) begin
            pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_mpp_recon.sv
// Scoreboard bench for dec_mpp_recon with directed blocks.
// Driver queues expected blocks; a negedge monitor checks each output.
module tb_dec_mpp_recon;

  localparam int NCOMP    = 3;
  localparam int NSAMP    = 16;
  localparam int QW       = 8;
  localparam int BITDEPTH = 8;
  localparam int QWD      = (NCOMP+1)*NSAMP*QW;
  localparam int PW       = NCOMP*NSAMP*BITDEPTH;

  logic            clk = 1'b0;
  logic            rstn;
  logic            in_vld;
  logic            in_rdy;
  logic [QWD-1:0]  in_qres;
  logic [2:0]      in_step;
  logic            slice_start;
  logic            out_vld;
  logic            out_rdy;
  logic [PW-1:0]   out_pix;
  logic [15:0]     blk_cnt;

  dec_mpp_recon #(
    .NCOMP(NCOMP), .NSAMP(NSAMP), .QW(QW), .BITDEPTH(BITDEPTH)
  ) dut (
    .clk(clk), .rstn(rstn),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .in_qres(in_qres), .in_step(in_step),
    .slice_start(slice_start),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_pix(out_pix), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pix;
    logic [15:0]   cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [PW-1:0] act,
                     input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", out_pix);
      end else begin
        e = sb.pop_front();
        chk("out_pix", out_pix, e.pix);
        chk("cnt_at_out", PW'(blk_cnt), PW'(e.cnt));
      end
    end
  end

  function automatic logic [PW-1:0] flat(input logic [7:0] v);
    logic [PW-1:0] p;
    for (int i = 0; i < NCOMP*NSAMP; i++)
      p[i*BITDEPTH +: BITDEPTH] = v;
    return p;
  endfunction

  function automatic logic [PW-1:0] setpix(input logic [PW-1:0] p,
    input int c, input int s, input logic [7:0] v);
    p[(c*NSAMP+s)*BITDEPTH +: BITDEPTH] = v;
    return p;
  endfunction

  function automatic logic [PW-1:0] setcomp(input logic [PW-1:0] p,
    input int c, input logic [7:0] v);
    for (int s = 0; s < NSAMP; s++)
      p[(c*NSAMP+s)*BITDEPTH +: BITDEPTH] = v;
    return p;
  endfunction

  function automatic logic [QWD-1:0] setq(input logic [QWD-1:0] q,
    input int k, input int j, input logic [7:0] v);
    q[(k*NSAMP+j)*QW +: QW] = v;
    return q;
  endfunction

  task automatic issue(input logic [QWD-1:0] q, input logic [2:0] st,
    input logic slc, input logic [PW-1:0] ep, input logic [15:0] ec);
    int n;
    exp_t x;
    x.pix = ep;
    x.cnt = ec;
    sb.push_back(x);
    in_qres = q;
    in_step = st;
    slice_start = slc;
    in_vld = 1'b1;
    n = 0;
    while (!in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL in_rdy_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    slice_start = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL out_vld_timeout: got 0 expected 1");
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  logic [QWD-1:0] q;
  logic [PW-1:0]  ex;
  logic [7:0]     mval;
  logic [PW-1:0]  c0p;
  int lat;

  initial begin
    rstn = 1'b0;
    in_vld = 1'b0;
    in_qres = '0;
    in_step = '0;
    slice_start = 1'b0;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("rst_in_rdy", PW'(in_rdy), PW'(1));
    chk("rst_out_vld", PW'(out_vld), PW'(0));
    chk("rst_out_pix", out_pix, '0);
    chk("rst_blk_cnt", PW'(blk_cnt), PW'(0));

    // first block, all zero residuals
    issue('0, 3'd0, 1'b0, flat(8'd128), 16'd0);
    wait_out(lat);
    chk("latency", PW'(lat), PW'(4));
    next_edge();
    chk("blk_cnt_a", PW'(blk_cnt), PW'(1));

    // mapping: c1 s1 from substream 0, c1 s4 from substream 2
    q = setq(setq('0, 0, 5, 8'd1), 2, 0, 8'd2);
    ex = setpix(setpix(flat(8'd128), 1, 1, 8'd132), 1, 4, 8'd136);
    issue(q, 3'd2, 1'b1, ex, 16'd0);
    wait_out(lat);
    next_edge();
    chk("blk_cnt_map1", PW'(blk_cnt), PW'(1));

`ifdef MPP_MEAN_ROUND_EN
    mval = 8'd129;
`else
    mval = 8'd128;
`endif
    issue('0, 3'd0, 1'b0, setcomp(flat(8'd128), 1, mval), 16'd1);
    wait_out(lat);
    next_edge();
    chk("blk_cnt_map2", PW'(blk_cnt), PW'(2));

    // clipping under backpressure
    out_rdy = 1'b0;
    q = setq('0, 0, 0, 8'h7F);
    q = setq(q, 0, 1, 8'h80);
    q = setq(q, 0, 2, 8'hF0);
    q = setq(q, 0, 3, 8'h0F);
    ex = setpix(flat(8'd128), 0, 0, 8'd255);
    ex = setpix(ex, 0, 1, 8'd0);
    ex = setpix(ex, 0, 2, 8'd0);
    ex = setpix(ex, 0, 3, 8'd248);
    issue(q, 3'd3, 1'b1, ex, 16'd0);
    wait_out(lat);
    next_edge();
    in_vld = 1'b1;
    in_qres = setq('0, 1, 0, 8'h11);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_vld", PW'(out_vld), PW'(1));
      chk("bp_in_rdy", PW'(in_rdy), PW'(0));
      chk("bp_blk_cnt", PW'(blk_cnt), PW'(0));
      chk("bp_out_pix", out_pix, ex);
      next_edge();
    end
    in_vld = 1'b0;
    out_rdy = 1'b1;
    next_edge();
    chk("blk_cnt_clip", PW'(blk_cnt), PW'(1));

    // c0 mean after clip block: 2039/16 -> 127 either way
    c0p = setcomp(flat(8'd128), 0, 8'd127);
    issue('0, 3'd0, 1'b0, c0p, 16'd1);
    wait_out(lat);
    next_edge();
    chk("blk_cnt_b3", PW'(blk_cnt), PW'(2));
    issue('0, 3'd0, 1'b0, c0p, 16'd2);
    wait_out(lat);
    next_edge();
    chk("blk_cnt_b4", PW'(blk_cnt), PW'(3));

    // slice start while the block is in RECON
    issue('0, 3'd0, 1'b0, c0p, 16'd3);
    slice_start = 1'b1;
    next_edge();
    slice_start = 1'b0;
    wait_out(lat);
    next_edge();
    chk("blk_cnt_slice", PW'(blk_cnt), PW'(0));
    issue('0, 3'd0, 1'b0, flat(8'd128), 16'd0);
    wait_out(lat);
    next_edge();
    chk("blk_cnt_after", PW'(blk_cnt), PW'(1));

    repeat (5) next_edge();
    chk("sb_drained", PW'(sb.size()), PW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dec_mpp_recon.md
# dec_mpp_recon

Parametrised midpoint-prediction (MPP) reconstruction for the VDC-M decoder. Takes one block of quantized MPP residuals from the NCOMP+1 substream demux outputs and redistributes them to per-component sample order (spec 4.6.3.5 layout). It then reconstructs each component against its own midpoint and returns the block on a valid/ready output. The block sits between the substream demultiplexer and the block reconstruction buffer, replacing the fixed 3-component, 16-sample mapping.

## Interface
- NCOMP, 3, colour components; substream channels = NCOMP+1
- NSAMP, 16, samples per component per block; power of 2, ≥4
- QW, 8, quantized residual width, two's complement
- BITDEPTH, 8, reconstructed sample width
- HEAD, NSAMP/4, leading samples of each component carried on substream 0; NCOMP*HEAD ≤ NSAMP
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- in_vld  in  1  residual block valid
- in_rdy  out  1  block accepted when in_vld & in_rdy
- in_qres  in  (NCOMP+1)*NSAMP*QW  substream k, entry j at [(k*NSAMP+j)*QW +: QW]
- in_step  in  3  quantizer step shift, 0..7
- slice_start  in  1  pulse; the next block is the first of a slice
- out_vld  out  1  reconstructed block valid
- out_rdy  in  1  downstream ready
- out_pix  out  NCOMP*NSAMP*BITDEPTH  component c, sample s at [(c*NSAMP+s)*BITDEPTH +: BITDEPTH]
- blk_cnt  out  16  blocks output since slice start

## Operation
- Mapping, applied at capture. Component c, sample s:
  - s < HEAD: taken from substream 0, entry c*HEAD+s.
  - otherwise: taken from substream c+1, entry s-HEAD.
  - Substream 0 entries ≥ NCOMP*HEAD are ignored.
- FSM:
  - IDLE: in_rdy=1. On handshake, capture the mapped residuals, in_step, and first = (blk_cnt==0). Go to RECON with comp=0.
  - RECON: process one component per cycle. comp increments; after comp==NCOMP-1, go to OUT.
  - OUT: out_vld=1. On out_rdy, blk_cnt increments (saturates at 0xFFFF) and the FSM returns to IDLE.
- Midpoint per component c:
  - mp = 1<<(BITDEPTH-1) when the block is first.
  - otherwise mp = mean[c], the stored mean of component c from the previous block.
- Reconstruction per sample: r = clip(mp + (sext(qres) <<< step), 0, 2^BITDEPTH-1).
  - Intermediate width: QW+BITDEPTH+8 signed; no overflow.
- Mean update: in the same RECON cycle, mean[c] <= sum(r over NSAMP) >> log2(NSAMP). The sum is BITDEPTH+log2(NSAMP) bits unsigned.
- slice_start:
  - In IDLE: blk_cnt <= 0 and all mean[c] <= 1<<(BITDEPTH-1). If slice_start coincides with a handshake, the accepted block is first.
  - In RECON/OUT: latched into a pending flag. It does not affect the block in flight. It is applied on the cycle the FSM enters IDLE; the out_rdy increment is overridden and blk_cnt becomes 0.
- in_rdy is deasserted in RECON and OUT; no second block is buffered.

## Timing
- Reset values:
  - state IDLE, in_rdy=1 (combinational from state).
  - out_vld=0, out_pix=0, blk_cnt=0.
  - all mean[c]=1<<(BITDEPTH-1); pending flag 0.
- Latency: handshake at edge T puts the FSM in RECON for edges T+1..T+NCOMP. out_vld is high in the cycle after edge T+NCOMP.
- Throughput: minimum NCOMP+2 cycles per block with out_rdy held high.
- out_pix is registered. It stays stable while out_vld & ~out_rdy.
- blk_cnt updates on the out handshake edge.
- rstn low in any state aborts the block and restores the reset values on the next edge.

## Configuration
- MPP_MEAN_ROUND_EN:
  - Defined: mean[c] = (sum + NSAMP/2) >> log2(NSAMP).
  - Undefined: mean[c] = sum >> log2(NSAMP), truncating.
- No other behaviour changes.

## Test plan
All scenarios use defaults NCOMP=3, NSAMP=16, QW=8, BITDEPTH=8.
- Reset: hold rstn low 3 cycles, then release -> in_rdy=1, out_vld=0, out_pix=0, blk_cnt=0.
- First block, all qres=0, step=0:
  - out_vld 4 cycles after handshake; all 48 samples = 128.
  - blk_cnt=1 after out_rdy.
- Mapping and prediction:
  - Block 1: substream 0 entry 5 = +1 (c1, s1) and substream 2 entry 0 = +2 (c1, s4), step=2, all else 0.
  - Expected block 1: c1 s1 = 132, c1 s4 = 136, all others 128.
  - Block 2: all qres=0. Expected c1 mean = (128*14+132+136)/16 = 128.75 -> c1 = 129 with MPP_MEAN_ROUND_EN, 128 without.
- Clipping: first block, step=3:
  - qres=+127 -> 255; qres=-128 -> 0.
  - qres=-16 -> 0 (128-128); qres=+15 -> 248.
- Backpressure: out_rdy=0 for 5 cycles after out_vld -> out_vld, out_pix and blk_cnt stable; in_rdy=0; in_vld ignored.
- slice_start during RECON after 3 blocks (blk_cnt=3):
  - The current block reconstructs with the old means.
  - blk_cnt=0 after its out handshake.
  - The next block with qres=0 outputs all 128; blk_cnt=1 after that block's handshake.
